// File: rtl/transition_generator_pkg.sv
// Shared definitions for the transition generator and its companion receivers/benches.
package transition_generator_pkg;

  localparam int unsigned DEF_COUNT_W = 64;
  localparam int unsigned DEF_GAP_W   = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/transition_generator_if.sv
// Job handshake, abort and serial-line status bundle of the transition generator.
interface transition_generator_if
  import transition_generator_pkg::*;
#(
  parameter int unsigned COUNT_W = DEF_COUNT_W,
  parameter int unsigned GAP_W   = DEF_GAP_W
);

  logic               start_valid;
  logic               start_ready;
  logic [COUNT_W-1:0] count;
  logic [GAP_W-1:0]   gap;
  logic               abort;
  logic               out;
  logic               busy;
  logic               done;
  logic [COUNT_W-1:0] sent;

  modport master (
    output start_valid, count, gap, abort,
    input  start_ready, out, busy, done, sent
  );

  modport slave (
    input  start_valid, count, gap, abort,
    output start_ready, out, busy, done, sent
  );

endinterface

// File: rtl/transition_generator_gap_timer.sv
// Down-counter spacing the transitions; expire_o flags a zero timer value.
module transition_generator_gap_timer
  import transition_generator_pkg::*;
#(
  parameter int unsigned GAP_W = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [GAP_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [GAP_W-1:0] timer_q, timer_d;

  // Load wins over decrement; the counter parks at zero instead of wrapping.
  always_comb begin
    timer_d = timer_q;
    if (load_i) begin
      timer_d = load_val_i;
    end else if (en_i && (timer_q != '0)) begin
      timer_d = timer_q - GAP_W'(1);
    end
  end

  // expire_o is registered alongside the counter so it tracks timer_q == 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q  <= '0;
      expire_o <= 1'b1;
    end else begin
      timer_q  <= timer_d;
      expire_o <= (timer_d == '0);
    end
  end

endmodule

// File: rtl/transition_generator.sv
// Emits a requested number of level transitions on a serial line, gap+1 cycles apart.
module transition_generator
  import transition_generator_pkg::*;
#(
  parameter int unsigned COUNT_W    = DEF_COUNT_W,
  parameter int unsigned GAP_W      = DEF_GAP_W,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  transition_generator_if.slave  bus
);

  state_e             state_q, state_d;
  logic               out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [COUNT_W-1:0] sent_q, sent_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic               tmr_load;
  logic               tmr_en;
  logic [GAP_W-1:0]   tmr_val;
  logic               tmr_expire;

  assign bus.start_ready = (state_q == S_IDLE) && !bus.abort;

  transition_generator_gap_timer #(
    .GAP_W (GAP_W)
  ) u_gap_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .en_i       (tmr_en),
    .load_val_i (tmr_val),
    .expire_o   (tmr_expire)
  );

  // Next-state: accept in IDLE; in RUN abort has priority over a due toggle.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sent_d   = sent_q;
    rem_d    = rem_q;
    gap_d    = gap_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = gap_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start_valid && bus.start_ready) begin
          rem_d    = bus.count;
          gap_d    = bus.gap;
          sent_d   = '0;
          tmr_load = 1'b1;
          tmr_val  = bus.gap;
          if (bus.count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (tmr_expire) begin
          out_d    = ~out_q;
          sent_d   = sent_q + COUNT_W'(1);
          rem_d    = rem_q - COUNT_W'(1);
          tmr_load = 1'b1;
          if (rem_q == COUNT_W'(1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      out_q   <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sent_q  <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sent_q  <= sent_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sent = sent_q;

endmodule

// File: tb/tb_transition_generator.sv
// Directed scenario bench for transition_generator with hand-computed expectations.
module tb_transition_generator;

  localparam int unsigned COUNT_W = 64;
  localparam int unsigned GAP_W   = 16;

  logic clk;
  logic reset;

  transition_generator_if #(.COUNT_W(COUNT_W), .GAP_W(GAP_W)) bus ();

  transition_generator #(
    .COUNT_W    (COUNT_W),
    .GAP_W      (GAP_W),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int toggles;
  int busy_cnt;
  int done_cnt;
  int done_step;
  int tog_q[$];
  logic exp_level;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [COUNT_W-1:0] cnt, input logic [GAP_W-1:0] gp);
    bus.start_valid = 1'b1;
    bus.count       = cnt;
    bus.gap         = gp;
    step();
    bus.start_valid = 1'b0;
  endtask

  // Runs n cycles recording toggles/busy/done; optional start_valid spam and abort.
  task automatic observe(input int n, input int sv_until, input int abort_at);
    logic prev;
    toggles   = 0;
    busy_cnt  = 0;
    done_cnt  = 0;
    done_step = -1;
    tog_q.delete();
    for (int i = 1; i <= n; i++) begin
      prev            = bus.out;
      bus.start_valid = (i <= sv_until);
      if (i <= sv_until) begin
        bus.count = 64'd7;
        bus.gap   = 16'd0;
      end
      bus.abort = (i == abort_at);
      step();
      bus.abort       = 1'b0;
      bus.start_valid = 1'b0;
      if (bus.out !== prev) begin
        toggles++;
        tog_q.push_back(i);
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_step = i;
      end
    end
  endtask

  task automatic test_reset();
    bus.start_valid = 1'b0;
    bus.count       = '0;
    bus.gap         = '0;
    bus.abort       = 1'b0;
    reset = 1'b0;
    #23;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) step();
    total++; if (bus.out !== 1'b0) begin bad++; $display("FAIL reset_out got=%b exp=0", bus.out); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.sent !== 64'd0) begin bad++; $display("FAIL reset_sent got=%0d exp=0", bus.sent); end
    total++; if (bus.start_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.start_ready); end
    // Mid-job asynchronous reset with the line high.
    accept(64'd3, 16'd3);
    observe(4, 0, 0);
    total++; if (bus.out !== 1'b1) begin bad++; $display("FAIL midjob_pre_out got=%b exp=1", bus.out); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (bus.out !== 1'b0) begin bad++; $display("FAIL midjob_reset_out got=%b exp=0", bus.out); end
    total++; if (bus.sent !== 64'd0) begin bad++; $display("FAIL midjob_reset_sent got=%0d exp=0", bus.sent); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midjob_reset_busy got=%b exp=0", bus.busy); end
    #1;
    reset = 1'b1;
    step();
    exp_level = 1'b0;
  endtask

  task automatic test_gap0();
    accept(64'd5, 16'd0);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL gap0_busy_at_accept got=%b exp=1", bus.busy); end
    total++; if (bus.sent !== 64'd0) begin bad++; $display("FAIL gap0_sent_at_accept got=%0d exp=0", bus.sent); end
    observe(8, 0, 0);
    exp_level = 1'b1;
    total++; if (toggles !== 5) begin bad++; $display("FAIL gap0_toggles got=%0d exp=5", toggles); end
    total++; if (tog_q[0] !== 1 || tog_q[4] !== 5) begin bad++; $display("FAIL gap0_toggle_steps got=%0d..%0d exp=1..5", tog_q[0], tog_q[4]); end
    total++; if (bus.out !== exp_level) begin bad++; $display("FAIL gap0_out got=%b exp=%b", bus.out, exp_level); end
    total++; if (bus.sent !== 64'd5) begin bad++; $display("FAIL gap0_sent got=%0d exp=5", bus.sent); end
    total++; if (done_cnt !== 1 || done_step !== 5) begin bad++; $display("FAIL gap0_done got=%0d@%0d exp=1@5", done_cnt, done_step); end
    total++; if (busy_cnt + 1 !== 5) begin bad++; $display("FAIL gap0_busy_cycles got=%0d exp=5", busy_cnt + 1); end
  endtask

  task automatic test_gap4_ignore_start();
    accept(64'd3, 16'd4);
    observe(18, 12, 0);
    exp_level = ~exp_level;
    total++; if (toggles !== 3) begin bad++; $display("FAIL gap4_toggles got=%0d exp=3", toggles); end
    total++; if (tog_q[0] !== 5 || tog_q[1] !== 10 || tog_q[2] !== 15) begin
      bad++; $display("FAIL gap4_toggle_steps got=%0d,%0d,%0d exp=5,10,15", tog_q[0], tog_q[1], tog_q[2]);
    end
    total++; if (bus.sent !== 64'd3) begin bad++; $display("FAIL gap4_sent got=%0d exp=3", bus.sent); end
    total++; if (done_step !== 15 || done_cnt !== 1) begin bad++; $display("FAIL gap4_done got=%0d@%0d exp=1@15", done_cnt, done_step); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL gap4_busy_after got=%b exp=0", bus.busy); end
    total++; if (bus.out !== exp_level) begin bad++; $display("FAIL gap4_out got=%b exp=%b", bus.out, exp_level); end
  endtask

  task automatic test_count0_back_to_back();
    accept(64'd0, 16'd0);
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL cnt0_done got=%b exp=1", bus.done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL cnt0_busy got=%b exp=0", bus.busy); end
    total++; if (bus.out !== exp_level) begin bad++; $display("FAIL cnt0_out got=%b exp=%b", bus.out, exp_level); end
    accept(64'd2, 16'd1);
    total++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL b2b_accept got=done%b busy%b exp=done0 busy1", bus.done, bus.busy);
    end
    observe(6, 0, 0);
    total++; if (toggles !== 2 || tog_q[0] !== 2 || tog_q[1] !== 4) begin
      bad++; $display("FAIL b2b_toggles got=%0d(%0d,%0d) exp=2(2,4)", toggles, tog_q[0], tog_q[1]);
    end
    total++; if (bus.out !== exp_level) begin bad++; $display("FAIL b2b_out got=%b exp=%b", bus.out, exp_level); end
    total++; if (done_step !== 4) begin bad++; $display("FAIL b2b_done_step got=%0d exp=4", done_step); end
  endtask

  task automatic test_abort();
    accept(64'd10, 16'd2);
    observe(14, 0, 12);
    exp_level = ~exp_level;
    total++; if (toggles !== 3) begin bad++; $display("FAIL abort_toggles got=%0d exp=3", toggles); end
    total++; if (bus.sent !== 64'd3) begin bad++; $display("FAIL abort_sent got=%0d exp=3", bus.sent); end
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL abort_done got=%0d exp=0", done_cnt); end
    total++; if (busy_cnt !== 11) begin bad++; $display("FAIL abort_busy_cycles got=%0d exp=11", busy_cnt); end
    total++; if (bus.out !== exp_level) begin bad++; $display("FAIL abort_out got=%b exp=%b", bus.out, exp_level); end
    // Abort in IDLE blocks the accept.
    bus.abort = 1'b1;
    #1;
    total++; if (bus.start_ready !== 1'b0) begin bad++; $display("FAIL idle_abort_ready got=%b exp=0", bus.start_ready); end
    bus.start_valid = 1'b1;
    bus.count       = 64'd1;
    bus.gap         = 16'd0;
    step();
    bus.abort       = 1'b0;
    bus.start_valid = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.sent !== 64'd3) begin
      bad++; $display("FAIL idle_abort_accept got=busy%b sent%0d exp=busy0 sent3", bus.busy, bus.sent);
    end
    accept(64'd1, 16'd0);
    observe(3, 0, 0);
    exp_level = ~exp_level;
    total++; if (bus.out !== exp_level || bus.sent !== 64'd1) begin
      bad++; $display("FAIL after_abort_job got=out%b sent%0d exp=out%b sent1", bus.out, bus.sent, exp_level);
    end
  endtask

  task automatic test_long_and_max();
    logic [COUNT_W-1:0] maxc;
    accept(64'd1000, 16'd0);
    observe(1005, 0, 0);
    total++; if (toggles !== 1000 || bus.sent !== 64'd1000) begin
      bad++; $display("FAIL long_count got=tog%0d sent%0d exp=1000", toggles, bus.sent);
    end
    total++; if (done_step !== 1000 || done_cnt !== 1) begin bad++; $display("FAIL long_done got=%0d@%0d exp=1@1000", done_cnt, done_step); end
    total++; if (bus.out !== exp_level) begin bad++; $display("FAIL long_out got=%b exp=%b", bus.out, exp_level); end
    maxc = '1;
    accept(maxc, 16'd0);
    observe(17, 0, 17);
    total++; if (bus.sent !== 64'd16 || toggles !== 16) begin
      bad++; $display("FAIL max_sent got=sent%0d tog%0d exp=16", bus.sent, toggles);
    end
    total++; if (bus.busy !== 1'b0 || done_cnt !== 0) begin
      bad++; $display("FAIL max_abort got=busy%b done%0d exp=busy0 done0", bus.busy, done_cnt);
    end
    total++; if (bus.out !== exp_level) begin bad++; $display("FAIL max_out got=%b exp=%b", bus.out, exp_level); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_level = 1'b0;
    test_reset();
    test_gap0();
    test_gap4_ignore_start();
    test_count0_back_to_back();
    test_abort();
    test_long_and_max();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
